// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: class/info bit indices, opcodes, and the decode bundle.
// Optional RV32M decode is enabled by defining DECODE_RVM_EN (used in decode_core).
package decode_stage_pkg;

    // One-hot instruction class vector
    localparam int DEC_CLASS_LEN = 12;
    localparam int CLS_LUI       = 0;
    localparam int CLS_AUIPC     = 1;
    localparam int CLS_JAL       = 2;
    localparam int CLS_JALR      = 3;
    localparam int CLS_BJP       = 4;
    localparam int CLS_ALU       = 5;
    localparam int CLS_ALUI      = 6;
    localparam int CLS_LOAD      = 7;
    localparam int CLS_STORE     = 8;
    localparam int CLS_CSR       = 9;
    localparam int CLS_SPECI     = 10;
    localparam int CLS_MULDIV    = 11;

    // Branch/jump op info
    localparam int BRU_BEQ  = 0;
    localparam int BRU_BNE  = 1;
    localparam int BRU_BLT  = 2;
    localparam int BRU_BGE  = 3;
    localparam int BRU_BLTU = 4;
    localparam int BRU_BGEU = 5;
    localparam int BRU_JAL  = 6;
    localparam int BRU_JALR = 7;
    localparam int BRU_INFO_LEN = 8;

    // Load/store info: access size one-hot (index = func3[1:0]), unsigned, store
    localparam int LSU_B     = 0;
    localparam int LSU_H     = 1;
    localparam int LSU_W     = 2;
    localparam int LSU_UNS   = 3;
    localparam int LSU_STORE = 4;
    localparam int LSU_INFO_LEN = 5;

    // ALU / ALU-immediate op info (shared layout)
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLL  = 2;
    localparam int ALU_SLT  = 3;
    localparam int ALU_SLTU = 4;
    localparam int ALU_XOR  = 5;
    localparam int ALU_SRL  = 6;
    localparam int ALU_SRA  = 7;
    localparam int ALU_OR   = 8;
    localparam int ALU_AND  = 9;
    localparam int ALU_INFO_LEN = 10;

    // CSR op info
    localparam int CSR_RW  = 0;
    localparam int CSR_RS  = 1;
    localparam int CSR_RC  = 2;
    localparam int CSR_IMM = 3;
    localparam int CSR_INFO_LEN = 4;

    // Special (system/fence) op info
    localparam int SPECI_ECALL  = 0;
    localparam int SPECI_EBREAK = 1;
    localparam int SPECI_MRET   = 2;
    localparam int SPECI_SRET   = 3;
    localparam int SPECI_WFI    = 4;
    localparam int SPECI_FENCE  = 5;
    localparam int SPECI_FENCEI = 6;
    localparam int SPECI_INFO_LEN = 7;

    // Mul/div op info, index equals func3
    localparam int MDU_MUL    = 0;
    localparam int MDU_MULH   = 1;
    localparam int MDU_MULHSU = 2;
    localparam int MDU_MULHU  = 3;
    localparam int MDU_DIV    = 4;
    localparam int MDU_DIVU   = 5;
    localparam int MDU_REM    = 6;
    localparam int MDU_REMU   = 7;
    localparam int MDU_INFO_LEN = 8;

    localparam int DECODE_INFO_LEN = 10;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ALUI   = 7'b0010011;
    localparam logic [6:0] OPC_ALU    = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // inst[31:20] of the func3=000 system instructions (rs1/rd must be zero)
    localparam logic [11:0] F12_ECALL  = 12'h000;
    localparam logic [11:0] F12_EBREAK = 12'h001;
    localparam logic [11:0] F12_SRET   = 12'h102;
    localparam logic [11:0] F12_MRET   = 12'h302;
    localparam logic [11:0] F12_WFI    = 12'h105;

    typedef struct packed {
        logic [DEC_CLASS_LEN-1:0]   cls;
        logic [DECODE_INFO_LEN-1:0] info;
        logic [31:0]                imm;
        logic                       rs1_en;
        logic                       rs2_en;
        logic                       rd_en;
        logic [4:0]                 rs1_idx;
        logic [4:0]                 rs2_idx;
        logic [4:0]                 rd_idx;
        logic [11:0]                csr_addr;
        logic                       illegal;
    } dec_t;

    // ALU op one-hot from func3; alt selects sub/sra
    function automatic logic [DECODE_INFO_LEN-1:0] alu_info(input logic [2:0] f3, input logic alt);
        logic [DECODE_INFO_LEN-1:0] v;
        v = '0;
        case (f3)
            3'b000:  v[alt ? ALU_SUB : ALU_ADD] = 1'b1;
            3'b001:  v[ALU_SLL]  = 1'b1;
            3'b010:  v[ALU_SLT]  = 1'b1;
            3'b011:  v[ALU_SLTU] = 1'b1;
            3'b100:  v[ALU_XOR]  = 1'b1;
            3'b101:  v[alt ? ALU_SRA : ALU_SRL] = 1'b1;
            3'b110:  v[ALU_OR]   = 1'b1;
            default: v[ALU_AND]  = 1'b1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/decode_core.sv
// Purely combinational RV32I decoder: inst -> class/info/imm/enables/illegal.
// Define DECODE_RVM_EN to decode RV32M mul/div as the muldiv class.
module decode_core
    import decode_stage_pkg::*;
(
    input  logic [31:0] i_inst,
    output dec_t        o_dec
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_rd_use;
    logic       w_ill;
    dec_t       w_dec;

    assign w_opc = i_inst[6:0];
    assign w_f3  = i_inst[14:12];
    assign w_f7  = i_inst[31:25];

    // Decode everything optimistically, then blank the bundle if any illegal case hit
    always_comb begin
        w_dec          = '0;
        w_rd_use       = 1'b0;
        w_ill          = 1'b0;
        w_dec.rs1_idx  = i_inst[19:15];
        w_dec.rs2_idx  = i_inst[24:20];
        w_dec.rd_idx   = i_inst[11:7];
        w_dec.csr_addr = i_inst[31:20];
        if (i_inst[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end else begin
            case (w_opc)
                OPC_LUI: begin
                    w_dec.cls[CLS_LUI] = 1'b1;
                    w_dec.imm          = {i_inst[31:12], 12'h000};
                    w_rd_use           = 1'b1;
                end
                OPC_AUIPC: begin
                    w_dec.cls[CLS_AUIPC] = 1'b1;
                    w_dec.imm            = {i_inst[31:12], 12'h000};
                    w_rd_use             = 1'b1;
                end
                OPC_JAL: begin
                    w_dec.cls[CLS_JAL]   = 1'b1;
                    w_dec.info[BRU_JAL]  = 1'b1;
                    w_dec.imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
                    w_rd_use  = 1'b1;
                end
                OPC_JALR: begin
                    w_dec.cls[CLS_JALR]  = 1'b1;
                    w_dec.info[BRU_JALR] = 1'b1;
                    w_dec.imm            = {{20{i_inst[31]}}, i_inst[31:20]};
                    w_dec.rs1_en         = 1'b1;
                    w_rd_use             = 1'b1;
                    w_ill                = (w_f3 != 3'b000);
                end
                OPC_BRANCH: begin
                    w_dec.cls[CLS_BJP] = 1'b1;
                    w_dec.imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
                    w_dec.rs1_en = 1'b1;
                    w_dec.rs2_en = 1'b1;
                    case (w_f3)
                        3'b000:  w_dec.info[BRU_BEQ]  = 1'b1;
                        3'b001:  w_dec.info[BRU_BNE]  = 1'b1;
                        3'b100:  w_dec.info[BRU_BLT]  = 1'b1;
                        3'b101:  w_dec.info[BRU_BGE]  = 1'b1;
                        3'b110:  w_dec.info[BRU_BLTU] = 1'b1;
                        3'b111:  w_dec.info[BRU_BGEU] = 1'b1;
                        default: w_ill = 1'b1;
                    endcase
                end
                OPC_LOAD: begin
                    w_dec.cls[CLS_LOAD] = 1'b1;
                    w_dec.imm           = {{20{i_inst[31]}}, i_inst[31:20]};
                    w_dec.rs1_en        = 1'b1;
                    w_rd_use            = 1'b1;
                    case (w_f3)
                        3'b000:  w_dec.info[LSU_B] = 1'b1;
                        3'b001:  w_dec.info[LSU_H] = 1'b1;
                        3'b010:  w_dec.info[LSU_W] = 1'b1;
                        3'b100:  w_dec.info[LSU_B +: 4] = 4'b1001;
                        3'b101:  w_dec.info[LSU_B +: 4] = 4'b1010;
                        default: w_ill = 1'b1;
                    endcase
                end
                OPC_STORE: begin
                    w_dec.cls[CLS_STORE]  = 1'b1;
                    w_dec.info[LSU_STORE] = 1'b1;
                    w_dec.imm    = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                    w_dec.rs1_en = 1'b1;
                    w_dec.rs2_en = 1'b1;
                    case (w_f3)
                        3'b000:  w_dec.info[LSU_B] = 1'b1;
                        3'b001:  w_dec.info[LSU_H] = 1'b1;
                        3'b010:  w_dec.info[LSU_W] = 1'b1;
                        default: w_ill = 1'b1;
                    endcase
                end
                OPC_ALUI: begin
                    w_dec.cls[CLS_ALUI] = 1'b1;
                    w_dec.info   = alu_info(w_f3, (w_f3 == 3'b101) & i_inst[30]);
                    w_dec.rs1_en = 1'b1;
                    w_rd_use     = 1'b1;
                    if (w_f3 == 3'b001) begin
                        w_dec.imm = {27'd0, i_inst[24:20]};
                        w_ill     = (i_inst[31:26] != 6'b000000);
                    end else if (w_f3 == 3'b101) begin
                        w_dec.imm = {27'd0, i_inst[24:20]};
                        w_ill     = (i_inst[31:26] != 6'b000000) && (i_inst[31:26] != 6'b010000);
                    end else begin
                        w_dec.imm = {{20{i_inst[31]}}, i_inst[31:20]};
                    end
                end
                OPC_ALU: begin
                    w_dec.rs1_en = 1'b1;
                    w_dec.rs2_en = 1'b1;
                    w_rd_use     = 1'b1;
                    if ((w_f7 == 7'b0000000) ||
                        ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))) begin
                        w_dec.cls[CLS_ALU] = 1'b1;
                        w_dec.info         = alu_info(w_f3, w_f7[5]);
                    end
`ifdef DECODE_RVM_EN
                    else if (w_f7 == 7'b0000001) begin
                        w_dec.cls[CLS_MULDIV] = 1'b1;
                        w_dec.info[w_f3]      = 1'b1;
                    end
`endif
                    else begin
                        w_ill = 1'b1;
                    end
                end
                OPC_FENCE: begin
                    w_dec.cls[CLS_SPECI] = 1'b1;
                    if (w_f3 == 3'b001) w_dec.info[SPECI_FENCEI] = 1'b1;
                    else                w_dec.info[SPECI_FENCE]  = 1'b1;
                end
                OPC_SYSTEM: begin
                    if (w_f3 == 3'b000) begin
                        w_dec.cls[CLS_SPECI] = 1'b1;
                        w_ill = (i_inst[19:7] != 13'd0);
                        case (i_inst[31:20])
                            F12_ECALL:  w_dec.info[SPECI_ECALL]  = 1'b1;
                            F12_EBREAK: w_dec.info[SPECI_EBREAK] = 1'b1;
                            F12_SRET:   w_dec.info[SPECI_SRET]   = 1'b1;
                            F12_MRET:   w_dec.info[SPECI_MRET]   = 1'b1;
                            F12_WFI:    w_dec.info[SPECI_WFI]    = 1'b1;
                            default:    w_ill = 1'b1;
                        endcase
                    end else begin
                        // csr ops; func3[2] selects the zero-extended uimm form
                        w_dec.cls[CLS_CSR]  = 1'b1;
                        w_dec.info[CSR_RW]  = (w_f3[1:0] == 2'b01);
                        w_dec.info[CSR_RS]  = (w_f3[1:0] == 2'b10);
                        w_dec.info[CSR_RC]  = (w_f3[1:0] == 2'b11);
                        w_dec.info[CSR_IMM] = w_f3[2];
                        w_dec.imm    = w_f3[2] ? {27'd0, i_inst[19:15]} : 32'd0;
                        w_dec.rs1_en = ~w_f3[2];
                        w_rd_use     = 1'b1;
                        w_ill        = (w_f3 == 3'b100);
                    end
                end
                default: w_ill = 1'b1;
            endcase
        end
        w_dec.rd_en = w_rd_use & (w_dec.rd_idx != 5'd0);
        if (w_ill) begin
            w_dec.cls     = '0;
            w_dec.info    = '0;
            w_dec.imm     = '0;
            w_dec.rs1_en  = 1'b0;
            w_dec.rs2_en  = 1'b0;
            w_dec.rd_en   = 1'b0;
            w_dec.illegal = 1'b1;
        end
    end

    assign o_dec = w_dec;

endmodule

// File: rtl/decode_stage.sv
// Registered ID stage: DEPTH-entry (inst, pc) FIFO, bypass when empty, registered decode bundle.
// Optional RV32M decode via macro DECODE_RVM_EN (handled inside decode_core).
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       if_valid_i,
    output logic                       if_ready_o,
    input  logic [31:0]                if_inst_i,
    input  logic [PC_W-1:0]            if_pc_i,
    output logic                       id_valid_o,
    input  logic                       id_ready_i,
    output logic [PC_W-1:0]            id_pc_o,
    output logic [DEC_CLASS_LEN-1:0]   id_class_o,
    output logic [DECODE_INFO_LEN-1:0] id_info_o,
    output logic [31:0]                id_imm_o,
    output logic                       id_rs1_en_o,
    output logic                       id_rs2_en_o,
    output logic                       id_rd_en_o,
    output logic [4:0]                 id_rs1_idx_o,
    output logic [4:0]                 id_rs2_idx_o,
    output logic [4:0]                 id_rd_idx_o,
    output logic [11:0]                id_csr_addr_o,
    output logic                       id_illegal_o
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]     r_inst_mem [DEPTH];
    logic [PC_W-1:0] r_pc_mem   [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW:0]     r_cnt;
    logic            r_vld;
    logic [PC_W-1:0] r_pc;
    dec_t            r_dec;

    logic            w_nempty;
    logic            w_in_fire;
    logic            w_load;
    logic            w_pop;
    logic            w_bypass;
    logic            w_push;
    logic [31:0]     w_src_inst;
    logic [PC_W-1:0] w_src_pc;
    dec_t            w_dec;

    assign w_nempty   = (r_cnt != '0);
    assign if_ready_o = (r_cnt != (PW+1)'(DEPTH));
    assign w_in_fire  = if_valid_i & if_ready_o & ~flush_i;
    // Output register is free when empty or being consumed this cycle
    assign w_load     = ~r_vld | id_ready_i;
    assign w_pop      = w_load & w_nempty & ~flush_i;
    assign w_bypass   = w_load & ~w_nempty & w_in_fire;
    assign w_push     = w_in_fire & ~w_bypass;
    assign w_src_inst = w_nempty ? r_inst_mem[r_rd_ptr] : if_inst_i;
    assign w_src_pc   = w_nempty ? r_pc_mem[r_rd_ptr]   : if_pc_i;

    decode_core u_core (
        .i_inst (w_src_inst),
        .o_dec  (w_dec)
    );

    // FIFO storage; contents need no reset, occupancy is tracked by r_cnt
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= if_inst_i;
            r_pc_mem[r_wr_ptr]   <= if_pc_i;
        end
    end

    // FIFO pointers and count; flush empties the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Output bundle register: loads from FIFO head, else bypasses the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_pc  <= '0;
            r_dec <= '0;
        end else if (flush_i) begin
            r_vld <= 1'b0;
        end else if (w_load) begin
            if (w_pop || w_bypass) begin
                r_vld <= 1'b1;
                r_pc  <= w_src_pc;
                r_dec <= w_dec;
            end else begin
                r_vld <= 1'b0;
            end
        end
    end

    assign id_valid_o    = r_vld;
    assign id_pc_o       = r_pc;
    assign id_class_o    = r_dec.cls;
    assign id_info_o     = r_dec.info;
    assign id_imm_o      = r_dec.imm;
    assign id_rs1_en_o   = r_dec.rs1_en;
    assign id_rs2_en_o   = r_dec.rs2_en;
    assign id_rd_en_o    = r_dec.rd_en;
    assign id_rs1_idx_o  = r_dec.rs1_idx;
    assign id_rs2_idx_o  = r_dec.rs2_idx;
    assign id_rd_idx_o   = r_dec.rd_idx;
    assign id_csr_addr_o = r_dec.csr_addr;
    assign id_illegal_o  = r_dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: hand vector table, directed corner sequences, random traffic vs a queue model.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
`ifdef DECODE_RVM_EN
    localparam bit RVM = 1'b1;
`else
    localparam bit RVM = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       flush_i = 1'b0;
    logic                       if_valid_i = 1'b0;
    logic                       if_ready_o;
    logic [31:0]                if_inst_i = '0;
    logic [PC_W-1:0]            if_pc_i = '0;
    logic                       id_valid_o;
    logic                       id_ready_i = 1'b0;
    logic [PC_W-1:0]            id_pc_o;
    logic [DEC_CLASS_LEN-1:0]   id_class_o;
    logic [DECODE_INFO_LEN-1:0] id_info_o;
    logic [31:0]                id_imm_o;
    logic                       id_rs1_en_o, id_rs2_en_o, id_rd_en_o;
    logic [4:0]                 id_rs1_idx_o, id_rs2_idx_o, id_rd_idx_o;
    logic [11:0]                id_csr_addr_o;
    logic                       id_illegal_o;

    decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_inst_i(if_inst_i), .if_pc_i(if_pc_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o),
        .id_class_o(id_class_o), .id_info_o(id_info_o), .id_imm_o(id_imm_o),
        .id_rs1_en_o(id_rs1_en_o), .id_rs2_en_o(id_rs2_en_o), .id_rd_en_o(id_rd_en_o),
        .id_rs1_idx_o(id_rs1_idx_o), .id_rs2_idx_o(id_rs2_idx_o), .id_rd_idx_o(id_rd_idx_o),
        .id_csr_addr_o(id_csr_addr_o), .id_illegal_o(id_illegal_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;
    item_t q[$];

    typedef struct {
        logic [31:0] inst;
        logic [11:0] cls;
        logic [31:0] imm;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_en;
        logic        ill;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        return 32'($signed(v << (32 - bits)) >>> (32 - bits));
    endfunction

    // Reference decode written from the ISA rules
    function automatic dec_t ref_decode(input logic [31:0] x);
        dec_t d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ok;
        int c;
        int alu_map[8];
        int br_map[8];
        alu_map = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        br_map  = '{BRU_BEQ, BRU_BNE, 0, 0, BRU_BLT, BRU_BGE, BRU_BLTU, BRU_BGEU};
        d = '0;
        op = x[6:0]; f3 = x[14:12]; f7 = x[31:25];
        d.rs1_idx = x[19:15]; d.rs2_idx = x[24:20]; d.rd_idx = x[11:7]; d.csr_addr = x[31:20];
        ok = 1'b1; c = 0;
        if (x[1:0] != 2'b11) ok = 1'b0;
        else begin
            case (op)
                7'b0110111: begin c = CLS_LUI;   d.imm = {x[31:12], 12'h000}; end
                7'b0010111: begin c = CLS_AUIPC; d.imm = {x[31:12], 12'h000}; end
                7'b1101111: begin
                    c = CLS_JAL; d.info[BRU_JAL] = 1'b1;
                    d.imm = sext({11'd0, x[31], x[19:12], x[20], x[30:21], 1'b0}, 21);
                end
                7'b1100111: begin
                    c = CLS_JALR; d.info[BRU_JALR] = 1'b1; ok = (f3 == 3'd0);
                    d.imm = sext(32'(x[31:20]), 12);
                end
                7'b1100011: begin
                    c = CLS_BJP; ok = !(f3 == 3'd2 || f3 == 3'd3);
                    if (ok) d.info[br_map[f3]] = 1'b1;
                    d.imm = sext({19'd0, x[31], x[7], x[30:25], x[11:8], 1'b0}, 13);
                end
                7'b0000011: begin
                    c = CLS_LOAD; ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
                    if (ok) begin d.info[f3[1:0]] = 1'b1; d.info[LSU_UNS] = f3[2]; end
                    d.imm = sext(32'(x[31:20]), 12);
                end
                7'b0100011: begin
                    c = CLS_STORE; ok = (f3 < 3'd3);
                    if (ok) d.info[f3[1:0]] = 1'b1;
                    d.info[LSU_STORE] = 1'b1;
                    d.imm = sext(32'({x[31:25], x[11:7]}), 12);
                end
                7'b0010011: begin
                    c = CLS_ALUI;
                    if (f3 == 3'd1) ok = (x[31:26] == 6'd0);
                    if (f3 == 3'd5) ok = (x[31:26] == 6'd0) || (x[31:26] == 6'b010000);
                    if (f3 == 3'd5 && x[30]) d.info[ALU_SRA] = 1'b1;
                    else d.info[alu_map[f3]] = 1'b1;
                    d.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(x[24:20]) : sext(32'(x[31:20]), 12);
                end
                7'b0110011: begin
                    c = CLS_ALU;
                    if (f7 == 7'h00) d.info[alu_map[f3]] = 1'b1;
                    else if (f7 == 7'h20 && f3 == 3'd0) d.info[ALU_SUB] = 1'b1;
                    else if (f7 == 7'h20 && f3 == 3'd5) d.info[ALU_SRA] = 1'b1;
                    else if (f7 == 7'h01 && RVM) begin c = CLS_MULDIV; d.info[f3] = 1'b1; end
                    else ok = 1'b0;
                end
                7'b0001111: begin
                    c = CLS_SPECI;
                    d.info[(f3 == 3'd1) ? SPECI_FENCEI : SPECI_FENCE] = 1'b1;
                end
                7'b1110011: begin
                    if (f3 == 3'd0) begin
                        c = CLS_SPECI;
                        case (x)
                            32'h00000073: d.info[SPECI_ECALL]  = 1'b1;
                            32'h00100073: d.info[SPECI_EBREAK] = 1'b1;
                            32'h10200073: d.info[SPECI_SRET]   = 1'b1;
                            32'h30200073: d.info[SPECI_MRET]   = 1'b1;
                            32'h10500073: d.info[SPECI_WFI]    = 1'b1;
                            default:      ok = 1'b0;
                        endcase
                    end else if (f3 == 3'd4) begin
                        ok = 1'b0;
                    end else begin
                        c = CLS_CSR;
                        d.info[f3[1:0] - 2'd1] = 1'b1;
                        d.info[CSR_IMM] = f3[2];
                        d.imm = f3[2] ? 32'(x[19:15]) : 32'd0;
                    end
                end
                default: ok = 1'b0;
            endcase
        end
        if (ok) begin
            d.cls[c]  = 1'b1;
            d.rs1_en  = !(c == CLS_LUI || c == CLS_AUIPC || c == CLS_JAL || c == CLS_SPECI ||
                          (c == CLS_CSR && f3[2]));
            d.rs2_en  = (c == CLS_BJP || c == CLS_STORE || c == CLS_ALU || c == CLS_MULDIV);
            d.rd_en   = !(c == CLS_BJP || c == CLS_STORE || c == CLS_SPECI) && (x[11:7] != 5'd0);
        end else begin
            d.illegal = 1'b1;
            d.info    = '0;
            d.imm     = '0;
        end
        return d;
    endfunction

    function automatic dec_t dut_bundle();
        dec_t a;
        a.cls = id_class_o; a.info = id_info_o; a.imm = id_imm_o;
        a.rs1_en = id_rs1_en_o; a.rs2_en = id_rs2_en_o; a.rd_en = id_rd_en_o;
        a.rs1_idx = id_rs1_idx_o; a.rs2_idx = id_rs2_idx_o; a.rd_idx = id_rd_idx_o;
        a.csr_addr = id_csr_addr_o; a.illegal = id_illegal_o;
        return a;
    endfunction

    // Stage holds at most DEPTH+1 instructions; output valid whenever anything is in flight
    task automatic check_state();
        chk("id_valid", 128'(id_valid_o), 128'(q.size() != 0));
        chk("if_ready", 128'(if_ready_o), 128'(q.size() < DEPTH + 1));
        if (q.size() != 0) begin
            chk("bundle", 128'(dut_bundle()), 128'(ref_decode(q[0].inst)));
            chk("pc", 128'(id_pc_o), 128'(q[0].pc));
        end
    endtask

    // One cycle: check at negedge, drive, advance the model, wait for next negedge
    task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic fl);
        bit in_fire, out_fire;
        item_t it;
        check_state();
        if_valid_i = v; if_inst_i = inst; if_pc_i = pc; id_ready_i = rdy; flush_i = fl;
        in_fire  = v && (q.size() < DEPTH + 1) && !fl;
        out_fire = (q.size() != 0) && rdy;
        if (out_fire) void'(q.pop_front());
        if (fl) q.delete();
        else if (in_fire) begin it.inst = inst; it.pc = pc; q.push_back(it); end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic add(input logic [31:0] inst, input logic [11:0] cls, input logic [31:0] imm,
                       input logic r1, input logic r2, input logic rd, input logic il);
        vec_t t;
        t.inst = inst; t.cls = cls; t.imm = imm;
        t.rs1_en = r1; t.rs2_en = r2; t.rd_en = rd; t.ill = il;
        tbl.push_back(t);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] x;
        logic [6:0] opc_tab [11];
        logic [31:0] sys_tab [5];
        opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        sys_tab = '{32'h00000073, 32'h00100073, 32'h10200073, 32'h30200073, 32'h10500073};
        x = $urandom;
        x[6:0] = opc_tab[$urandom_range(0, 10)];
        case ($urandom_range(0, 3))
            0: x[31:25] = 7'h00;
            1: x[31:25] = 7'h20;
            2: x[31:25] = 7'h01;
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) x[11:7] = 5'd0;
        if ($urandom_range(0, 9) == 0) x = sys_tab[$urandom_range(0, 4)];
        if ($urandom_range(0, 19) == 0) x[1:0] = 2'($urandom);
        return x;
    endfunction

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 128'(id_valid_o), 128'(0));
        chk("rst_ready", 128'(if_ready_o), 128'(1));
        chk("rst_bundle", 128'(dut_bundle()), 128'(0));
        chk("rst_pc", 128'(id_pc_o), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Hand-derived single-instruction vectors
        add(32'h00500093, 12'h040, 32'd5,        1, 0, 1, 0); // addi x1,x0,5
        add(32'h0020A423, 12'h100, 32'd8,        1, 1, 0, 0); // sw x2,8(x1)
        add(32'hFFFFFFFF, 12'h000, 32'd0,        0, 0, 0, 1);
        add(32'h00000013, 12'h040, 32'd0,        1, 0, 0, 0); // addi x0,x0,0
        if (RVM) add(32'h023100B3, 12'h800, 32'd0, 1, 1, 1, 0); // mul x1,x2,x3
        else     add(32'h023100B3, 12'h000, 32'd0, 0, 0, 0, 1);
        add(32'h123452B7, 12'h001, 32'h12345000, 0, 0, 1, 0); // lui x5
        add(32'hFE208EE3, 12'h010, 32'hFFFFFFFC, 1, 1, 0, 0); // beq x1,x2,-4
        add(32'h008000EF, 12'h004, 32'd8,        0, 0, 1, 0); // jal x1,8
        add(32'h0000B083, 12'h000, 32'd0,        0, 0, 0, 1); // load func3 011
        add(32'h0000A083, 12'h080, 32'd0,        1, 0, 1, 0); // lw x1,0(x1)
        add(32'h3002D0F3, 12'h200, 32'd5,        0, 0, 1, 0); // csrrwi x1,0x300,5
        add(32'h00000073, 12'h400, 32'd0,        0, 0, 0, 0); // ecall
        add(32'h402090B3, 12'h000, 32'd0,        0, 0, 0, 1); // func7 0100000 with sll
        add(32'h000090E7, 12'h000, 32'd0,        0, 0, 0, 1); // jalr func3 001
        add(32'h4030D093, 12'h040, 32'd3,        1, 0, 1, 0); // srai x1,x1,3
        add(32'h00500092, 12'h000, 32'd0,        0, 0, 0, 1); // inst[1:0] = 10
        add(32'h0000000F, 12'h400, 32'd0,        0, 0, 0, 0); // fence
        foreach (tbl[i]) begin
            cyc(1'b1, tbl[i].inst, 32'h1000 + 32'(i) * 4, 1'b1, 1'b0);
            chk("t_valid",  128'(id_valid_o),   128'(1));
            chk("t_class",  128'(id_class_o),   128'(tbl[i].cls));
            chk("t_imm",    128'(id_imm_o),     128'(tbl[i].imm));
            chk("t_rs1_en", 128'(id_rs1_en_o),  128'(tbl[i].rs1_en));
            chk("t_rs2_en", 128'(id_rs2_en_o),  128'(tbl[i].rs2_en));
            chk("t_rd_en",  128'(id_rd_en_o),   128'(tbl[i].rd_en));
            chk("t_illegal",128'(id_illegal_o), 128'(tbl[i].ill));
            cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        drain();

        // Back-pressure: six pushes with issue stalled, only DEPTH+1 are taken
        for (int k = 0; k < 6; k++)
            cyc(1'b1, 32'h00000093 | (32'(k + 1) << 7), 32'h100 + 32'(k) * 4, 1'b0, 1'b0);
        chk("full_ready", 128'(if_ready_o), 128'(0));
        for (int k = 0; k < 5; k++) begin
            chk("order_valid", 128'(id_valid_o), 128'(1));
            chk("order_pc", 128'(id_pc_o), 128'(32'h100 + 32'(k) * 4));
            cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        chk("drained_valid", 128'(id_valid_o), 128'(0));

        // Flush with three buffered plus a valid output and a concurrent input
        for (int k = 0; k < 4; k++)
            cyc(1'b1, 32'h00100093, 32'h200 + 32'(k) * 4, 1'b0, 1'b0);
        cyc(1'b1, 32'h00700393, 32'hDEAD, 1'b1, 1'b1);
        chk("flush_valid", 128'(id_valid_o), 128'(0));
        chk("flush_ready", 128'(if_ready_o), 128'(1));
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
            chk("flush_gone", 128'(id_valid_o), 128'(0));
        end

        // Random traffic against the queue model
        for (int n = 0; n < 600; n++)
            cyc($urandom_range(0, 3) != 0, rand_inst(), 32'h4000 + 32'(n) * 4,
                $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);

        // Asynchronous reset mid-stream with two buffered
        drain();
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 32'h00500093, 32'h300 + 32'(k) * 4, 1'b0, 1'b0);
        if_valid_i = 1'b0; id_ready_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("rst_async_valid", 128'(id_valid_o), 128'(0));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_bundle", 128'(dut_bundle()), 128'(0));
        chk("rst2_pc", 128'(id_pc_o), 128'(0));
        chk("rst2_ready", 128'(if_ready_o), 128'(1));
        for (int k = 0; k < 4; k++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b1, 32'h00500093, 32'h500, 1'b1, 1'b0);
        chk("post_rst_pc", 128'(id_pc_o), 128'(32'h500));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
